// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl
//   Takes bytes from the UART receiver and writes them into the text RAM at a
//   managed cursor position. It also interprets CR, LF, BS and FF
//   (clear screen), so the display behaves like a small terminal.
//
//   State table:
//     state | meaning
//     IDLE  | waiting for an rx_valid rising edge; classify and service the byte
//     CLEAR | blank sweep over every cell in row-major order; bytes are dropped
//
// Ports:
//   clk       system clock; all logic runs on the rising edge
//   reset     synchronous, active-low reset
//   rx_data   received byte
//   rx_valid  receiver strobe (a level); only its rising edge is used
//   ram_we    text RAM write enable, one cycle per write (registered)
//   ram_row   write row address (registered)
//   ram_col   write column address (registered)
//   ram_data  write data (registered)
//   cur_row   cursor row
//   cur_col   cursor column
//   busy      high while a clear sweep runs
//   drop      one-cycle pulse when a byte arriving during the sweep is discarded
module text_cursor_ctrl #(
   parameter int         COLS  = 32,
   parameter int         ROWS  = 4,
   parameter int         COL_W = 5,
   parameter int         ROW_W = 2,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             ram_we,
   output logic [ROW_W-1:0] ram_row,
   output logic [COL_W-1:0] ram_col,
   output logic [7:0]       ram_data,
   output logic [ROW_W-1:0] cur_row,
   output logic [COL_W-1:0] cur_col,
   output logic             busy,
   output logic             drop
);

   localparam int SW = ROW_W + COL_W;
   localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
   localparam logic [SW-1:0]    SWEEP_MAX = SW'(ROWS * COLS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state, nxt_state;
   logic             rx_q;
   logic [SW-1:0]    sweep, nxt_sweep;
   logic [ROW_W-1:0] nxt_row;
   logic [COL_W-1:0] nxt_col;
   logic             nxt_we;
   logic [ROW_W-1:0] nxt_wrow;
   logic [COL_W-1:0] nxt_wcol;
   logic [7:0]       nxt_wdata;
   logic             nxt_drop;
   logic             accept;
   logic [SW-1:0]    sweep_inc;

   assign accept    = rx_valid & ~rx_q;
   assign sweep_inc = sweep + 1'b1;
   assign busy      = (state == CLEAR);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         rx_q     <= 1'b1;
         sweep    <= '0;
         cur_row  <= '0;
         cur_col  <= '0;
         ram_we   <= 1'b0;
         ram_row  <= '0;
         ram_col  <= '0;
         ram_data <= '0;
         drop     <= 1'b0;
      end else begin
         state    <= nxt_state;
         rx_q     <= rx_valid;
         sweep    <= nxt_sweep;
         cur_row  <= nxt_row;
         cur_col  <= nxt_col;
         ram_we   <= nxt_we;
         ram_row  <= nxt_wrow;
         ram_col  <= nxt_wcol;
         ram_data <= nxt_wdata;
         drop     <= nxt_drop;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_sweep = sweep;
      nxt_row   = cur_row;
      nxt_col   = cur_col;
      nxt_we    = 1'b0;
      nxt_wrow  = ram_row;
      nxt_wcol  = ram_col;
      nxt_wdata = ram_data;
      nxt_drop  = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                  nxt_we    = 1'b1;
                  nxt_wrow  = cur_row;
                  nxt_wcol  = cur_col;
                  nxt_wdata = rx_data;
                  if (cur_col == COL_MAX) begin
                     nxt_col = '0;
                     nxt_row = cur_row + 1'b1;
                  end else begin
                     nxt_col = cur_col + 1'b1;
                  end
               end else if (rx_data == 8'h0D) begin
                  nxt_col = '0;
               end else if (rx_data == 8'h0A) begin
                  nxt_col = '0;
                  nxt_row = cur_row + 1'b1;
               end else if (rx_data == 8'h08) begin
                  if (cur_col != '0) begin
                     nxt_col   = cur_col - 1'b1;
                     nxt_we    = 1'b1;
                     nxt_wrow  = cur_row;
                     nxt_wcol  = cur_col - 1'b1;
                     nxt_wdata = BLANK;
                  end else if (cur_row != '0) begin
                     nxt_row   = cur_row - 1'b1;
                     nxt_col   = COL_MAX;
                     nxt_we    = 1'b1;
                     nxt_wrow  = cur_row - 1'b1;
                     nxt_wcol  = COL_MAX;
                     nxt_wdata = BLANK;
                  end
               end else if (rx_data == 8'h0C) begin
                  // The first sweep write (cell 0) is registered here, so the
                  // ROWS*COLS writes line up exactly with the busy window.
                  nxt_state = CLEAR;
                  nxt_sweep = '0;
                  nxt_we    = 1'b1;
                  nxt_wrow  = '0;
                  nxt_wcol  = '0;
                  nxt_wdata = BLANK;
               end
            end
         end
         CLEAR: begin
            nxt_drop = accept;
            // sweep holds the address currently on the RAM bus
            if (sweep == SWEEP_MAX) begin
               nxt_state = IDLE;
               nxt_row   = '0;
               nxt_col   = '0;
            end else begin
               nxt_sweep              = sweep_inc;
               nxt_we                 = 1'b1;
               {nxt_wrow, nxt_wcol}   = sweep_inc;
               nxt_wdata              = BLANK;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

endmodule
